// File: rtl/hyperram_pkg.sv
// Shared types and constants for the HyperRAM transaction sequencer.
package hyperram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_WAIT,
        ST_WDATA,
        ST_RDATA,
        ST_RECOV
    } hr_state_t;

    // Command/address word layout.
    localparam int CA_W         = 48;
    localparam int CA_RW_BIT    = 47;  // 1 = read
    localparam int CA_AS_BIT    = 46;  // 0 = memory space
    localparam int CA_BURST_BIT = 45;  // 1 = linear burst
    localparam int CA_ROW_MSB   = 44;  // upper address bits addr[31:3]
    localparam int CA_ROW_LSB   = 16;
    localparam int CA_COL_MSB   = 2;   // lower address bits addr[2:0]

    localparam int DEF_LATENCY  = 6;
    localparam int DEF_TCSHI    = 2;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hyperram_ca_pack.sv
// Builds the 48-bit HyperRAM command/address word from direction and address.
module hyperram_ca_pack
    import hyperram_pkg::*;
(
    input  logic            we_i,
    input  logic [31:0]     addr_i,
    output logic [CA_W-1:0] ca_o
);

    // Assemble the command/address word field by field.
    always_comb begin
        // NOTE: default the whole output first so no path through the block leaves a bit unassigned (which would infer a latch).
        ca_o                         = '0;
        ca_o[CA_RW_BIT]              = ~we_i;
        ca_o[CA_AS_BIT]              = 1'b0;
        ca_o[CA_BURST_BIT]           = 1'b1;
        ca_o[CA_ROW_MSB:CA_ROW_LSB]  = addr_i[31:3];
        ca_o[CA_COL_MSB:0]           = addr_i[2:0];
    end

endmodule

// File: rtl/hyperram_seq.sv
// HyperRAM transaction sequencer: command/address, initial latency, data
// phase and CS# recovery, all on clk0; the I/O buffer does the DDR work.
module hyperram_seq
    import hyperram_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int RD_PIPE = 3,
    parameter int TCSHI   = DEF_TCSHI,
    parameter int LEN_W   = 6
) (
    input  logic             clk0,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             ack,
    output logic             busy,
    input  logic [15:0]      wdata,
    output logic             wr_ready,
    output logic [15:0]      rdata,
    output logic             rd_valid,
    output logic             done,
    output logic             cs_n,
    output logic [15:0]      dq_out,
    input  logic [15:0]      dq_in,
    output logic             oe_data,
    output logic             oe_clk,
    input  logic             rwds_in,
    output logic             rwds_oe,
    output logic             rwds_out
);

    // One down-counter serves every phase; size it for the longest one.
    localparam int CNT_MAX = imax(imax(2 * LATENCY, 1 << LEN_W),
                                  imax(TCSHI, RD_PIPE + (1 << LEN_W)));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CA_FIRST  = cnt_t'(2);            // CA runs 2,1,0
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t WAIT_1X   = cnt_t'(LATENCY - 1);
    localparam cnt_t WAIT_2X   = cnt_t'(2 * LATENCY - 1);
    localparam cnt_t RD_PIPE_C = cnt_t'(RD_PIPE);
    localparam cnt_t RECOV_LD  = cnt_t'(TCSHI - 1);

    hr_state_t        state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic             dbl_q;
    logic [15:0]      wd_q;
    logic             accept;
    logic [CA_W-1:0]  ca;
    cnt_t             len_ext;

    assign len_ext = cnt_t'(len_q);

    hyperram_ca_pack u_ca_pack (
        .we_i   (we_q),
        .addr_i (addr_q),
        .ca_o   (ca)
    );

    // Next state, counter reload and per-cycle I/O buffer controls.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
        accept   = 1'b0;
        ack      = 1'b0;
        busy     = (state_q != ST_IDLE);
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        done     = 1'b0;
        cs_n     = 1'b1;
        dq_out   = '0;
        oe_data  = 1'b0;
        oe_clk   = 1'b0;
        rwds_oe  = 1'b0;
        rwds_out = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = req;
            end
            ST_CA: begin
                cs_n    = 1'b0;
                oe_clk  = 1'b1;
                oe_data = 1'b1;
                ack     = (cnt_q == CA_FIRST);
                case (cnt_q)
                    CA_FIRST: dq_out = ca[47:32];
                    CNT_ONE:  dq_out = ca[31:16];
                    default:  dq_out = ca[15:0];
                endcase
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = dbl_q ? WAIT_2X : WAIT_1X;
                end
            end
            ST_WAIT: begin
                cs_n   = 1'b0;
                oe_clk = 1'b1;
                if (cnt_q == '0) begin
                    // Fetch the first write word one cycle ahead of WDATA.
                    wr_ready = we_q;
                    state_d  = we_q ? ST_WDATA : ST_RDATA;
                    cnt_d    = we_q ? len_ext : len_ext + RD_PIPE_C;
                end
            end
            ST_WDATA: begin
                cs_n     = 1'b0;
                oe_clk   = 1'b1;
                oe_data  = 1'b1;
                rwds_oe  = 1'b1;
                dq_out   = wd_q;
                wr_ready = (cnt_q != '0);
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_RECOV;
                    cnt_d   = RECOV_LD;
                end
            end
            ST_RDATA: begin
                // Counter spans len+1 clocked cycles followed by the
                // RD_PIPE drain; words return in the last len+1 cycles.
                cs_n     = 1'b0;
                oe_clk   = (cnt_q >= RD_PIPE_C);
                rd_valid = (cnt_q <= len_ext);
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_RECOV;
                    cnt_d   = RECOV_LD;
                end
            end
            ST_RECOV: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    // A held request starts straight after recovery so
                    // CS# stays high for exactly TCSHI cycles.
                    accept  = req;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_CA;
            cnt_d   = CA_FIRST;
        end

        rdata = rd_valid ? dq_in : '0;
    end

    // State, counter and transaction registers with synchronous reset.
    always_ff @(posedge clk0) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            dbl_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q   <= we;
                addr_q <= addr;
                len_q  <= len;
            end
            if (state_q == ST_CA && cnt_q == CNT_ONE) begin
                dbl_q <= rwds_in;
            end
            if (wr_ready) begin
                wd_q <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_hyperram_seq.sv
// Self-checking bench for hyperram_seq: a table of burst transactions plus
// directed back-to-back and mid-burst reset sequences.
module tb_hyperram_seq;

    localparam int LATENCY = 6;
    localparam int RD_PIPE = 3;
    localparam int TCSHI   = 2;
    localparam int LEN_W   = 6;

    logic             clk0    = 1'b0;
    logic             rst_n   = 1'b0;
    logic             req     = 1'b0;
    logic             we      = 1'b0;
    logic [31:0]      addr    = '0;
    logic [LEN_W-1:0] len     = '0;
    logic [15:0]      wdata   = '0;
    logic [15:0]      dq_in   = '0;
    logic             rwds_in = 1'b0;

    logic        ack, busy, wr_ready, rd_valid, done, cs_n;
    logic        oe_data, oe_clk, rwds_oe, rwds_out;
    logic [15:0] rdata, dq_out;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [41:0] RESET_VEC = {9'b0, 1'b1, 16'h0000, 16'h0000};

    typedef struct {
        logic             we;
        logic [31:0]      addr;
        logic [LEN_W-1:0] len;
        logic             dbl;
        int               exp_wait;
        logic [47:0]      exp_ca;
        int               glitch;   // cycle of a stray req pulse, -1 = none
    } txn_t;

    txn_t tbl[5];

    hyperram_seq #(
        .LATENCY (LATENCY),
        .RD_PIPE (RD_PIPE),
        .TCSHI   (TCSHI),
        .LEN_W   (LEN_W)
    ) dut (
        .clk0     (clk0),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .len      (len),
        .ack      (ack),
        .busy     (busy),
        .wdata    (wdata),
        .wr_ready (wr_ready),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .done     (done),
        .cs_n     (cs_n),
        .dq_out   (dq_out),
        .dq_in    (dq_in),
        .oe_data  (oe_data),
        .oe_clk   (oe_clk),
        .rwds_in  (rwds_in),
        .rwds_oe  (rwds_oe),
        .rwds_out (rwds_out)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [41:0] outs();
        return {ack, busy, wr_ready, rd_valid, done, oe_data, oe_clk, rwds_oe, rwds_out,
                cs_n, dq_out, rdata};
    endfunction

    function automatic logic [15:0] wpat(input int seed, input int k);
        return 16'(32'hC000 + seed * 256 + k);
    endfunction

    function automatic logic [15:0] rpat(input int i);
        return 16'(32'h3000 + i);
    endfunction

    // One complete transaction from request to return to IDLE, observed
    // 1 time unit after each rising edge; inputs for the cycle set then.
    task automatic run_txn(input txn_t t, input int seed);
        int i, acks, ack_at, dones, done_at, first_rv, rv_cnt, rv_err;
        int w_cnt, d_cnt, d_err, wait_cyc, clk_cyc, cs_hi, bad;
        int exp_last, exp_total;
        logic [47:0] ca_seen;
        bit fin;
        acks = 0; ack_at = -1; dones = 0; done_at = -1; first_rv = -1;
        rv_cnt = 0; rv_err = 0; w_cnt = 0; d_cnt = 0; d_err = 0;
        wait_cyc = 0; clk_cyc = 0; cs_hi = 0; bad = 0; ca_seen = '0;
        exp_last  = 3 + t.exp_wait + int'(t.len) + (t.we ? 0 : RD_PIPE);
        exp_total = exp_last + 1 + TCSHI;
        we = t.we; addr = t.addr; len = t.len; req = 1'b1;
        i = 0; fin = 0;
        while (!fin && i < 300) begin
            @(posedge clk0);
            dq_in = rpat(i);
            #1;
            if (!busy) begin
                fin = 1;
            end else begin
                if (ack) begin
                    acks++;
                    if (ack_at < 0) ack_at = i;
                end
                if (i < 3) ca_seen = {ca_seen[31:0], dq_out};
                if (i >= 3 && !cs_n && oe_clk) begin
                    clk_cyc++;
                    if (!oe_data) wait_cyc++;
                end
                if (oe_data && rwds_oe) begin
                    if (dq_out !== wpat(seed, d_cnt) || rwds_out !== 1'b0) d_err++;
                    d_cnt++;
                end
                if (rd_valid) begin
                    rv_cnt++;
                    if (first_rv < 0) first_rv = i;
                    if (rdata !== rpat(i)) rv_err++;
                end
                if (done) begin
                    dones++;
                    done_at = i;
                end
                if (cs_n) cs_hi++;
                if (cs_n && (oe_clk || oe_data || rwds_oe)) bad++;
                if (i == 0) req = 1'b0;
                if (i == t.glitch) begin
                    req = 1'b1; we = ~t.we; addr = ~t.addr;
                end else if (t.glitch >= 0 && i == t.glitch + 1) begin
                    req = 1'b0; we = t.we; addr = t.addr;
                end
                rwds_in = (i == 1) ? t.dbl : ((i < 3) ? ~t.dbl : 1'b0);
                if (wr_ready) begin
                    wdata = wpat(seed, w_cnt);
                    w_cnt++;
                end
                i++;
            end
        end
        req = 1'b0; rwds_in = 1'b0;
        check("txn_finished", 64'(fin), 64'(1));
        check("ack_count", 64'(acks), 64'(1));
        check("ack_cycle", 64'(ack_at), 64'(0));
        check("ca_words", 64'(ca_seen), 64'(t.exp_ca));
        check("busy_cycles", 64'(i), 64'(exp_total));
        check("done_count", 64'(dones), 64'(1));
        check("done_cycle", 64'(done_at), 64'(exp_last));
        check("cs_high_recovery", 64'(cs_hi), 64'(TCSHI));
        check("enable_while_cs_high", 64'(bad), 64'(0));
        if (t.we) begin
            check("wr_wait_cycles", 64'(wait_cyc), 64'(t.exp_wait));
            check("wr_ready_count", 64'(w_cnt), 64'(int'(t.len) + 1));
            check("wr_word_count", 64'(d_cnt), 64'(int'(t.len) + 1));
            check("wr_word_errors", 64'(d_err), 64'(0));
            check("wr_no_rd_valid", 64'(rv_cnt), 64'(0));
        end else begin
            check("rd_clocked_cycles", 64'(clk_cyc), 64'(t.exp_wait + int'(t.len) + 1));
            check("rd_first_valid", 64'(first_rv), 64'(3 + t.exp_wait + RD_PIPE));
            check("rd_valid_count", 64'(rv_cnt), 64'(int'(t.len) + 1));
            check("rd_data_errors", 64'(rv_err), 64'(0));
            check("rd_no_data_drive", 64'(d_cnt), 64'(0));
        end
    endtask

    initial begin
        int i, acks, hi, ack2_at, busy_gap, d;
        logic [15:0] w2;
        bit fin, hit;

        tbl[0] = '{1'b1, 32'h0000_0010, 6'd3,  1'b0, 6,  48'h2000_0002_0000, -1};
        tbl[1] = '{1'b0, 32'h0001_2345, 6'd0,  1'b1, 12, 48'hA000_2468_0005, -1};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF, 6'd63, 1'b0, 6,  48'hBFFF_FFFF_0007, -1};
        tbl[3] = '{1'b1, 32'h8000_0008, 6'd0,  1'b1, 12, 48'h3000_0001_0000, -1};
        tbl[4] = '{1'b1, 32'h0000_0007, 6'd5,  1'b0, 6,  48'h2000_0000_0007, 5};

        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(posedge clk0);
        #1;
        check("reset_values", 64'(outs()), 64'(RESET_VEC));
        rst_n = 1'b1;
        @(posedge clk0);
        #1;

        for (int k = 0; k < 5; k++) begin
            run_txn(tbl[k], k);
        end

        // Back-to-back: write then read with req held across the first ack.
        req = 1'b1; we = 1'b1; addr = 32'h0000_0100; len = 6'd1;
        i = 0; acks = 0; hi = 0; ack2_at = -1; busy_gap = 0; w2 = '0; fin = 0;
        while (!fin && i < 200) begin
            @(posedge clk0);
            #1;
            if (acks == 1 && !ack && cs_n) hi++;
            if (acks == 1 && !busy) busy_gap++;
            if (ack) begin
                acks++;
                if (acks == 1) begin
                    we = 1'b0; addr = 32'h0000_0200; len = 6'd0;
                end else begin
                    ack2_at = i; w2 = dq_out; req = 1'b0;
                end
            end else if (acks >= 2 && !busy) begin
                fin = 1;
            end
            if (wr_ready) wdata = 16'h1234;
            i++;
        end
        req = 1'b0;
        check("b2b_finished", 64'(fin), 64'(1));
        check("b2b_ack_count", 64'(acks), 64'(2));
        check("b2b_second_ack_cycle", 64'(ack2_at), 64'(13));
        check("b2b_cs_high_gap", 64'(hi), 64'(TCSHI));
        check("b2b_busy_gap", 64'(busy_gap), 64'(0));
        check("b2b_second_ca0", 64'(w2), 64'(16'hA000));

        // Reset asserted during WDATA word 2 of a 4-word write.
        req = 1'b1; we = 1'b1; addr = 32'h0000_0040; len = 6'd3;
        i = 0; d = 0; hit = 0;
        while (!hit && i < 50) begin
            @(posedge clk0);
            #1;
            if (i == 0) req = 1'b0;
            if (wr_ready) wdata = 16'(32'hBE00 + i);
            if (oe_data && rwds_oe) begin
                if (d == 2) begin
                    rst_n = 1'b0;
                    hit = 1;
                end
                d++;
            end
            i++;
        end
        check("mid_reset_reached_word2", 64'(hit), 64'(1));
        @(posedge clk0);
        #1;
        check("mid_reset_outputs", 64'(outs()), 64'(RESET_VEC));
        @(posedge clk0);
        #1;
        rst_n = 1'b1;
        run_txn(tbl[0], 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
